// File: rtl/piso_shifter.sv
// piso_shifter: parallel-in, serial-out shift register.
//
// Accepts a WIDTH-bit word through a valid/ready handshake and emits it one
// bit per enabled clock on serial_out. Framing strobes mark the first and
// last bit of each frame. A new word can be accepted on the edge that
// consumes the last bit of the current frame, so back-to-back frames leave
// no idle gap.
//
// Parameters
//   WIDTH      word length in bits (2..32)
//   MSB_FIRST  1 = bit WIDTH-1 leaves first, 0 = bit 0 leaves first
//
// Ports
//   clock         rising-edge clock
//   clear         asynchronous, active-high reset
//   load_valid    data_in holds a word to transmit
//   load_ready    block accepts a word this cycle (combinational)
//   data_in       parallel word, sampled only on a load handshake
//   shift_en      sink consumes the current serial bit; 0 stalls everything
//   serial_out    current serial bit (driven from register state only)
//   serial_valid  serial_out carries a frame bit
//   frame_start   first bit of a frame is presented
//   frame_last    last bit of a frame is presented
module piso_shifter #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             shift_en,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             frame_last
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   shreg, shreg_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [WIDTH-1:0]   shifted;
    logic               at_last;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        shreg_nxt  = shreg;
        cnt_nxt    = cnt;
        load_ready = 1'b0;

        // Zero-filled shift toward whichever end feeds serial_out.
        if (MSB_FIRST != 0) begin
            shifted = {shreg[WIDTH-2:0], 1'b0};
        end else begin
            shifted = {1'b0, shreg[WIDTH-1:1]};
        end

        at_last = (cnt == LAST_IDX);

        case (state)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    shreg_nxt = data_in;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // Ready only on the edge that retires the last bit, which
                // lets the next frame follow without a gap cycle.
                load_ready = at_last && shift_en;
                if (shift_en) begin
                    if (at_last) begin
                        cnt_nxt = '0;
                        if (load_valid) begin
                            shreg_nxt = data_in;
                        end else begin
                            shreg_nxt = shifted;
                            state_nxt = IDLE;
                        end
                    end else begin
                        shreg_nxt = shifted;
                        cnt_nxt   = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are decoded from state and register contents only, so a stall
    // or an ignored load request never disturbs the bit on the line.
    always_comb begin
        serial_valid = (state == SHIFT);
        serial_out   = 1'b0;
        frame_start  = 1'b0;
        frame_last   = 1'b0;
        if (state == SHIFT) begin
            serial_out  = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
            frame_start = (cnt == '0);
            frame_last  = at_last;
        end
    end

endmodule

// File: tb/tb_piso_shifter.sv
// Directed bench for piso_shifter. Two instances share all inputs: dut_m
// (MSB first) and dut_l (LSB first). Their strobes always agree; only the
// serial bit order differs.
module tb_piso_shifter;

    logic       clock;
    logic       clear;
    logic       load_valid;
    logic [3:0] data_in;
    logic       shift_en;

    logic m_ready, m_out, m_valid, m_start, m_last;
    logic l_ready, l_out, l_valid, l_start, l_last;

    int checks   = 0;
    int failures = 0;

    piso_shifter #(.WIDTH(4), .MSB_FIRST(1)) dut_m (
        .clock        (clock),
        .clear        (clear),
        .load_valid   (load_valid),
        .load_ready   (m_ready),
        .data_in      (data_in),
        .shift_en     (shift_en),
        .serial_out   (m_out),
        .serial_valid (m_valid),
        .frame_start  (m_start),
        .frame_last   (m_last)
    );

    piso_shifter #(.WIDTH(4), .MSB_FIRST(0)) dut_l (
        .clock        (clock),
        .clear        (clear),
        .load_valid   (load_valid),
        .load_ready   (l_ready),
        .data_in      (data_in),
        .shift_en     (shift_en),
        .serial_out   (l_out),
        .serial_valid (l_valid),
        .frame_start  (l_start),
        .frame_last   (l_last)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic cmp(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Waits 1 time unit so freshly driven inputs settle, then checks dut_m.
    task automatic chk(input string tag, input logic v, input logic o,
                       input logic fs, input logic fl, input logic rdy);
        #1;
        cmp({tag, "_valid"}, m_valid, v);
        cmp({tag, "_out"},   m_out,   o);
        cmp({tag, "_start"}, m_start, fs);
        cmp({tag, "_last"},  m_last,  fl);
        cmp({tag, "_ready"}, m_ready, rdy);
    endtask

    // Checks dut_l without advancing time (call right after chk).
    task automatic chk_l(input string tag, input logic v, input logic o,
                         input logic fs, input logic fl, input logic rdy);
        cmp({tag, "_lvalid"}, l_valid, v);
        cmp({tag, "_lout"},   l_out,   o);
        cmp({tag, "_lstart"}, l_start, fs);
        cmp({tag, "_llast"},  l_last,  fl);
        cmp({tag, "_lready"}, l_ready, rdy);
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    initial begin
        clear      = 1'b1;
        load_valid = 1'b0;
        data_in    = 4'b0000;
        shift_en   = 1'b1;

        // Reset values while clear is held
        chk("rst", 0, 0, 0, 0, 1);
        chk_l("rst", 0, 0, 0, 0, 1);
        #11;
        clear = 1'b0;
        tick;

        // MSB first, 1011 -> 1,0,1,1 ; LSB first -> 1,1,0,1
        load_valid = 1'b1;
        data_in    = 4'b1011;
        chk("t1_idle", 0, 0, 0, 0, 1);
        tick;
        load_valid = 1'b0;
        chk("t1_b1", 1, 1, 1, 0, 0);  chk_l("t2_b1", 1, 1, 1, 0, 0);
        tick;
        chk("t1_b2", 1, 0, 0, 0, 0);  chk_l("t2_b2", 1, 1, 0, 0, 0);
        tick;
        chk("t1_b3", 1, 1, 0, 0, 0);  chk_l("t2_b3", 1, 0, 0, 0, 0);
        tick;
        chk("t1_b4", 1, 1, 0, 1, 1);  chk_l("t2_b4", 1, 1, 0, 1, 1);
        tick;
        chk("t1_end", 0, 0, 0, 0, 1); chk_l("t2_end", 0, 0, 0, 0, 1);

        // Back-to-back: 1011 then 0110 held -> 1,0,1,1,0,1,1,0
        load_valid = 1'b1;
        data_in    = 4'b1011;
        tick;
        data_in = 4'b0110;
        chk("t3_b1", 1, 1, 1, 0, 0);
        tick;
        chk("t3_b2", 1, 0, 0, 0, 0);
        tick;
        chk("t3_b3", 1, 1, 0, 0, 0);
        tick;
        chk("t3_b4", 1, 1, 0, 1, 1);
        tick;
        load_valid = 1'b0;
        chk("t3_b5", 1, 0, 1, 0, 0);
        tick;
        chk("t3_b6", 1, 1, 0, 0, 0);
        tick;
        chk("t3_b7", 1, 1, 0, 0, 0);
        tick;
        chk("t3_b8", 1, 0, 0, 1, 1);
        tick;
        chk("t3_end", 0, 0, 0, 0, 1);

        // Stall on bit 2 for 3 extra cycles, then one stall on the last bit
        load_valid = 1'b1;
        data_in    = 4'b1011;
        tick;
        load_valid = 1'b0;
        chk("t4_b1", 1, 1, 1, 0, 0);
        tick;
        shift_en = 1'b0;
        chk("t4_b2", 1, 0, 0, 0, 0);
        tick;
        chk("t4_s1", 1, 0, 0, 0, 0);
        tick;
        chk("t4_s2", 1, 0, 0, 0, 0);
        tick;
        shift_en = 1'b1;
        chk("t4_s3", 1, 0, 0, 0, 0);
        tick;
        chk("t4_b3", 1, 1, 0, 0, 0);
        tick;
        shift_en = 1'b0;
        chk("t4_b4stall", 1, 1, 0, 1, 0);
        tick;
        shift_en = 1'b1;
        chk("t4_b4", 1, 1, 0, 1, 1);
        tick;
        chk("t4_end", 0, 0, 0, 0, 1);

        // Load request while busy at counter 1 is ignored
        load_valid = 1'b1;
        data_in    = 4'b1011;
        tick;
        load_valid = 1'b0;
        chk("t5_b1", 1, 1, 1, 0, 0);
        tick;
        load_valid = 1'b1;
        data_in    = 4'b1111;
        chk("t5_b2", 1, 0, 0, 0, 0);
        tick;
        load_valid = 1'b0;
        chk("t5_b3", 1, 1, 0, 0, 0);
        tick;
        chk("t5_b4", 1, 1, 0, 1, 1);
        tick;
        chk("t5_end", 0, 0, 0, 0, 1);

        // Asynchronous clear during bit 2, then a fresh frame of 0101
        load_valid = 1'b1;
        data_in    = 4'b1011;
        tick;
        load_valid = 1'b0;
        chk("t6_b1", 1, 1, 1, 0, 0);
        tick;
        chk("t6_b2", 1, 0, 0, 0, 0);  chk_l("t6_b2", 1, 1, 0, 0, 0);
        #2;
        clear = 1'b1;
        chk("t6_clr", 0, 0, 0, 0, 1); chk_l("t6_clr", 0, 0, 0, 0, 1);
        #1;
        clear = 1'b0;
        chk("t6_rel", 0, 0, 0, 0, 1); chk_l("t6_rel", 0, 0, 0, 0, 1);
        load_valid = 1'b1;
        data_in    = 4'b0101;
        tick;
        load_valid = 1'b0;
        chk("t6_n1", 1, 0, 1, 0, 0);  chk_l("t6_n1", 1, 1, 1, 0, 0);
        tick;
        chk("t6_n2", 1, 1, 0, 0, 0);  chk_l("t6_n2", 1, 0, 0, 0, 0);
        tick;
        chk("t6_n3", 1, 0, 0, 0, 0);  chk_l("t6_n3", 1, 1, 0, 0, 0);
        tick;
        chk("t6_n4", 1, 1, 0, 1, 1);  chk_l("t6_n4", 1, 0, 0, 1, 1);
        tick;
        chk("t6_end", 0, 0, 0, 0, 1); chk_l("t6_end", 0, 0, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/piso_shifter.md
Name: piso_shifter

Overview:
Parallel-in, serial-out shift register with a valid/ready load handshake and framing strobes. It accepts a WIDTH-bit word and emits it one bit per enabled clock on a single serial line. It is the transmit-side counterpart of the team's serial-in/parallel-out capture register, and a serial link is built from one of each. It supports stall via shift_en and back-to-back frames with no idle gap.

Parameters:
WIDTH, 4, word length in bits; legal range 2..32.
MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
clock  input  1  single clock; all state updates on its rising edge.
clear  input  1  asynchronous, active-high reset.
load_valid  input  1  data_in holds a word to transmit.
load_ready  output  1  block can accept a word this cycle.
data_in  input  WIDTH  parallel word; sampled only on a load handshake.
shift_en  input  1  sink consumes the current serial bit this cycle; 0 = stall.
serial_out  output  1  current serial bit.
serial_valid  output  1  serial_out carries a frame bit.
frame_start  output  1  high while the first bit of a frame is presented.
frame_last  output  1  high while the last bit of a frame is presented.

Behaviour:
- Reset (clear=1, asynchronous, takes effect immediately without a clock edge): state=IDLE, shift register=0, bit counter=0.
- Reset output values: serial_valid=0, serial_out=0, frame_start=0, frame_last=0, load_ready=1.
- Clear asserted mid-frame: the frame is aborted and the remaining bits are discarded. The first post-reset handshake starts a fresh frame.
- States: IDLE and SHIFT.
- IDLE:
  - load_ready=1, serial_valid=0, serial_out=0.
  - load_valid=1 at a rising edge: capture data_in, counter=0, go to SHIFT.
- SHIFT:
  - serial_valid=1.
  - serial_out = shift register MSB when MSB_FIRST=1, LSB when MSB_FIRST=0. It is driven from register state only, not from inputs.
  - frame_start=1 when counter==0. frame_last=1 when counter==WIDTH-1.
  - shift_en=1 at an edge: shift toward the output end (zero fill) and increment the counter.
  - shift_en=0: register, counter and all outputs hold. Stall length is unbounded.
  - Last-bit edge (counter==WIDTH-1 and shift_en=1): if load_valid=1, capture data_in, counter=0, stay in SHIFT (back-to-back frame, no gap cycle). Otherwise go to IDLE.
- load_ready = (state==IDLE) OR (state==SHIFT AND counter==WIDTH-1 AND shift_en). It is combinational from state, counter and shift_en.
  - load_valid while load_ready=0 is ignored; data_in is not sampled.
  - The source must hold load_valid and data_in until a handshake completes.
- Latency:
  - Handshake at edge N puts bit 0 of the frame on serial_out after edge N.
  - With shift_en held high, a frame occupies exactly WIDTH cycles.
- Counter width: clog2(WIDTH) bits, with no wrap beyond WIDTH-1. The counter resets to 0 on every load.
- Simultaneous frame_start and frame_last are impossible because WIDTH is at least 2.

Test Plan:
- WIDTH=4, MSB_FIRST=1, shift_en=1. Load 4'b1011 from IDLE -> serial_out 1,0,1,1 on the 4 cycles after the handshake, with serial_valid=1 throughout. frame_start on cycle 1, frame_last on cycle 4. Next cycle: IDLE, serial_valid=0, load_ready=1.
- MSB_FIRST=0. Load 4'b1011 -> serial_out 1,1,0,1 with the same strobe timing.
- Back-to-back: load 4'b1011, then hold load_valid with data 4'b0110 -> load_ready pulses on the frame_last cycle. Output is 8 contiguous valid bits 1,0,1,1,0,1,1,0, with frame_start on bits 1 and 5.
- Stall: load 4'b1011, drop shift_en for 3 cycles after bit 2 -> serial_out holds 0 with serial_valid=1 for 4 cycles total. Bits 3 and 4 (1,1) then follow and frame_last aligns with bit 4.
- Ignored load: pulse load_valid with 4'b1111 while a frame is at counter 1 -> load_ready=0, and the current frame 1,0,1,1 completes unchanged.
- Clear mid-frame: assert clear between edges during bit 2 -> serial_valid, serial_out, frame_start and frame_last drop to 0 and load_ready goes to 1 before the next edge. After release, loading 4'b0101 yields 0,1,0,1.
